// File: rtl/kanagawa_fifo_stream_adapter.sv
// rtl/kanagawa_fifo_stream_adapter.sv - drains a show-ahead FIFO into a registered valid/ready stream
// Options: KANAGAWA_STREAM_STATS_EN adds saturating xfer/stall counters; NO_DYNAMIC_ASSERTS drops sim checks.
module kanagawa_fifo_stream_adapter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_q,
    output logic             fifo_rdreq,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy
`ifdef KANAGAWA_STREAM_STATS_EN
    ,
    output logic [31:0]      xfer_count,
    output logic [31:0]      stall_count
`endif
);

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    logic [1:0]       occ_q;
    logic [1:0]       occ_d;
    logic             valid_q;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] head_d;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;
    logic             pop;
    logic             xfer;

    // Pop decision uses only registered occupancy, so out_ready never reaches fifo_rdreq.
    assign pop        = rst_n && !fifo_empty && (occ_q != OCC_FULL);
    assign xfer       = valid_q && out_ready;
    assign fifo_rdreq = pop;
    assign out_valid  = valid_q;
    assign out_data   = head_q;
    assign occupancy  = occ_q;

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        skid_d = skid_q;
        case (occ_q)
            OCC_EMPTY: begin
                if (pop) begin
                    head_d = fifo_q;
                    occ_d  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (pop && xfer) begin
                    head_d = fifo_q;
                end else if (pop) begin
                    skid_d = fifo_q;
                    occ_d  = OCC_FULL;
                end else if (xfer) begin
                    occ_d  = OCC_EMPTY;
                end
            end
            default: begin
                // Full: no pop can happen, the skid word moves up on transfer.
                if (xfer) begin
                    head_d = skid_q;
                    occ_d  = OCC_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            occ_q   <= OCC_EMPTY;
            valid_q <= 1'b0;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            occ_q   <= occ_d;
            valid_q <= (occ_d != OCC_EMPTY);
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

`ifdef KANAGAWA_STREAM_STATS_EN
    logic [31:0] xfer_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (xfer && (xfer_cnt_q != 32'hFFFF_FFFF)) begin
                xfer_cnt_q <= xfer_cnt_q + 32'd1;
            end
            if (valid_q && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign xfer_count  = xfer_cnt_q;
    assign stall_count = stall_cnt_q;
`endif

`ifndef NO_DYNAMIC_ASSERTS
    a_rdreq_nonempty: assert property (@(posedge clock) disable iff (!rst_n)
        fifo_rdreq |-> !fifo_empty);
    a_occ_range: assert property (@(posedge clock) disable iff (!rst_n)
        occ_q <= OCC_FULL);
    a_hold_stable: assert property (@(posedge clock) disable iff (!rst_n)
        (valid_q && !out_ready) |=> $stable(head_q));
`endif

endmodule

// File: tb/tb_kanagawa_fifo_stream_adapter.sv
// tb/tb_kanagawa_fifo_stream_adapter.sv - randomized bench for kanagawa_fifo_stream_adapter against a queue model
`timescale 1ns/1ps
module tb_kanagawa_fifo_stream_adapter;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         rst_n;
    logic         fifo_empty;
    logic [W-1:0] fifo_q;
    logic         fifo_rdreq;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic [1:0]   occupancy;
`ifdef KANAGAWA_STREAM_STATS_EN
    logic [31:0]  xfer_count;
    logic [31:0]  stall_count;
`endif

    always #5 clock = ~clock;

    kanagawa_fifo_stream_adapter #(.WIDTH(W)) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_q     (fifo_q),
        .fifo_rdreq (fifo_rdreq),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .occupancy  (occupancy)
`ifdef KANAGAWA_STREAM_STATS_EN
        ,
        .xfer_count (xfer_count),
        .stall_count(stall_count)
`endif
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // up_q: upstream FIFO contents; mdl: words the adapter must hold, oldest first; got: delivered words
    logic [W-1:0] up_q[$];
    logic [W-1:0] mdl[$];
    logic [W-1:0] got[$];
    logic [W-1:0] sent[$];
    logic         hide = 1'b0;
    logic         pop_m;
    logic         xfer_m;
    logic [31:0]  exp_xfers  = '0;
    logic [31:0]  exp_stalls = '0;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic drive_fifo();
        fifo_empty = (up_q.size() == 0) || hide;
        fifo_q     = (up_q.size() != 0) ? up_q[0] : 32'hDEAD_BEEF;
    endtask

    task automatic push(input logic [W-1:0] w);
        up_q.push_back(w);
        sent.push_back(w);
        drive_fifo();
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        drive_fifo();
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        hide = 1'b0;
        out_ready = 1'b1;
        drive_fifo();
        while ((up_q.size() != 0 || mdl.size() != 0) && n < limit) begin
            tick();
            n++;
        end
        check("drain_done", 64'(up_q.size() == 0 && mdl.size() == 0), 64'(1));
    endtask

    // Compare process: a word popped when the adapter holds <2 words, delivered oldest-first.
    always @(negedge clock) begin
        if (!rst_n) begin
            check("rst_valid", 64'(out_valid), 64'(0));
            check("rst_occ",   64'(occupancy), 64'(0));
            check("rst_rdreq", 64'(fifo_rdreq), 64'(0));
            check("rst_data",  64'(out_data), 64'(0));
            mdl.delete();
            exp_xfers  = '0;
            exp_stalls = '0;
`ifdef KANAGAWA_STREAM_STATS_EN
            check("rst_xfer_count",  64'(xfer_count), 64'(0));
            check("rst_stall_count", 64'(stall_count), 64'(0));
`endif
        end else begin
            pop_m  = !fifo_empty && (mdl.size() < 2);
            xfer_m = (mdl.size() != 0) && out_ready;
            check("rdreq",     64'(fifo_rdreq), 64'(pop_m));
            check("valid",     64'(out_valid), 64'(mdl.size() != 0));
            check("occupancy", 64'(occupancy), 64'(mdl.size()));
            if (mdl.size() != 0) check("data", 64'(out_data), 64'(mdl[0]));
`ifdef KANAGAWA_STREAM_STATS_EN
            check("xfer_count",  64'(xfer_count), 64'(exp_xfers));
            check("stall_count", 64'(stall_count), 64'(exp_stalls));
`endif
            if (xfer_m) begin
                got.push_back(mdl.pop_front());
                exp_xfers = sat_inc(exp_xfers);
            end else if (mdl.size() != 0) begin
                exp_stalls = sat_inc(exp_stalls);
            end
            if (pop_m) mdl.push_back(up_q.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, chk_cnt);
        $fatal(1);
    end

    initial begin
        logic [W-1:0] exp4 [4];
        int bad;
        exp4 = '{32'h11, 32'h22, 32'h33, 32'h44};

        // Reset with a non-empty FIFO: nothing popped, outputs idle
        rst_n = 1'b0;
        out_ready = 1'b0;
        push(32'hBAD0_0001);
        #3;
        check("t1_rdreq", 64'(fifo_rdreq), 64'(0));
        check("t1_valid", 64'(out_valid), 64'(0));
        check("t1_occ",   64'(occupancy), 64'(0));
        tick();
        tick();
        up_q.delete();
        sent.delete();
        drive_fifo();
        rst_n = 1'b1;

        // Streaming with no bubbles
        out_ready = 1'b1;
        push(32'h11); push(32'h22); push(32'h33);
        tick();
        check("t2_d0", 64'(out_data), 64'(32'h11));
        check("t2_o0", 64'(occupancy), 64'(1));
        tick();
        check("t2_d1", 64'(out_data), 64'(32'h22));
        check("t2_o1", 64'(occupancy), 64'(1));
        tick();
        check("t2_d2", 64'(out_data), 64'(32'h33));
        check("t2_v2", 64'(out_valid), 64'(1));
        tick();
        check("t2_v3", 64'(out_valid), 64'(0));
        check("t2_o3", 64'(occupancy), 64'(0));

        // Backpressure fills to two, then releases in order
        got.delete();
        out_ready = 1'b0;
        push(32'h11); push(32'h22); push(32'h33); push(32'h44);
        tick();
        check("t3_o1", 64'(occupancy), 64'(1));
        tick();
        check("t3_o2", 64'(occupancy), 64'(2));
        tick();
        check("t3_rdreq", 64'(fifo_rdreq), 64'(0));
        check("t3_hold",  64'(out_data), 64'(32'h11));
        check("t3_o2b",   64'(occupancy), 64'(2));
        drain(40);
        check("t3_count", 64'(got.size()), 64'(4));
        for (int i = 0; i < 4 && i < got.size(); i++) check("t3_order", 64'(got[i]), 64'(exp4[i]));

        // Random traffic against the scoreboard
        got.delete();
        sent.delete();
        for (int c = 0; c < 1000; c++) begin
            if ($urandom_range(0, 2) != 0 && up_q.size() < 4) push($urandom);
            hide = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            drive_fifo();
            tick();
        end
        drain(100);
        check("t4_count", 64'(got.size()), 64'(sent.size()));
        bad = 0;
        for (int i = 0; i < got.size() && i < sent.size(); i++) if (got[i] !== sent[i]) bad++;
        check("t4_order", 64'(bad), 64'(0));

        // Reset while full discards buffered words
        out_ready = 1'b0;
        push(32'hA1); push(32'hA2); push(32'hA3);
        tick(); tick(); tick();
        check("t5_full", 64'(occupancy), 64'(2));
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_valid", 64'(out_valid), 64'(0));
        check("t5_occ",   64'(occupancy), 64'(0));
        check("t5_rdreq", 64'(fifo_rdreq), 64'(0));
        up_q.delete();
        drive_fifo();
        tick();
        tick();
        rst_n = 1'b1;
        got.delete();
        push(32'h55); push(32'h66);
        drain(20);
        check("t5_first", 64'((got.size() != 0) ? got[0] : 32'h0), 64'(32'h55));

`ifdef KANAGAWA_STREAM_STATS_EN
        // Five transfers with three stall cycles, then saturation
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(32'h100 + i);
        tick(); tick(); tick(); tick();
        drain(30);
        check("t6_xfers",  64'(xfer_count), 64'(5));
        check("t6_stalls", 64'(stall_count), 64'(3));
        dut.xfer_cnt_q = 32'hFFFF_FFFE;
        exp_xfers = 32'hFFFF_FFFE;
        push(32'h200); push(32'h201); push(32'h202);
        drain(30);
        check("t6_sat", 64'(xfer_count), 64'(32'hFFFF_FFFF));
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
